// File: rtl/axi_arbiter.sv
// axi_arbiter: two-master to one-slave AXI-lite arbiter.
//   IFU master : read only (ar/r)
//   LSU master : read (ar/r) and write (aw/w/b)
//   m_*        : single downstream memory bus
// Single-beat transfers, one outstanding transaction. A grant is held from the
// address phase until the response handshake.
//
// Handshake semantics: a beat transfers on a rising clk edge where valid and
// ready are both 1. Upstream masters keep valid high until their response,
// so the *_done flags block re-issue of an address/data phase that has already
// been accepted by the bus.
//
// Ports: clk, rst (synchronous, active high), ifu_ar/ifu_r, lsu_ar/lsu_r,
// lsu_aw/lsu_w/lsu_b, m_ar/m_r/m_aw/m_w/m_b, dbg_state (current FSM state).
module axi_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int STRB_W = 8,
  parameter bit RR_EN  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ifu_ar_addr,
  input  logic              ifu_ar_valid,
  output logic              ifu_ar_ready,
  output logic [DATA_W-1:0] ifu_r_data,
  output logic [1:0]        ifu_r_resp,
  output logic              ifu_r_valid,
  input  logic              ifu_r_ready,
  input  logic [ADDR_W-1:0] lsu_ar_addr,
  input  logic              lsu_ar_valid,
  output logic              lsu_ar_ready,
  output logic [DATA_W-1:0] lsu_r_data,
  output logic [1:0]        lsu_r_resp,
  output logic              lsu_r_valid,
  input  logic              lsu_r_ready,
  input  logic [ADDR_W-1:0] lsu_aw_addr,
  input  logic              lsu_aw_valid,
  output logic              lsu_aw_ready,
  input  logic [DATA_W-1:0] lsu_w_data,
  input  logic [STRB_W-1:0] lsu_w_strb,
  input  logic              lsu_w_valid,
  output logic              lsu_w_ready,
  output logic [1:0]        lsu_b_resp,
  output logic              lsu_b_valid,
  input  logic              lsu_b_ready,
  output logic [ADDR_W-1:0] m_ar_addr,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  input  logic [DATA_W-1:0] m_r_data,
  input  logic [1:0]        m_r_resp,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  output logic [ADDR_W-1:0] m_aw_addr,
  output logic              m_aw_valid,
  input  logic              m_aw_ready,
  output logic [DATA_W-1:0] m_w_data,
  output logic [STRB_W-1:0] m_w_strb,
  output logic              m_w_valid,
  input  logic              m_w_ready,
  input  logic [1:0]        m_b_resp,
  input  logic              m_b_valid,
  output logic              m_b_ready,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFU_RD = 2'd1,
    LSU_RD = 2'd2,
    LSU_WR = 2'd3
  } state_t;

  localparam logic GNT_IFU = 1'b0;
  localparam logic GNT_LSU = 1'b1;

  state_t state, state_nxt;
  logic   ar_done, ar_done_nxt;
  logic   aw_done, aw_done_nxt;
  logic   w_done, w_done_nxt;
  logic   last_gnt, last_gnt_nxt;
  logic   aw_fin, w_fin;

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ar_done  <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      last_gnt <= GNT_IFU;
    end else begin
      state    <= state_nxt;
      ar_done  <= ar_done_nxt;
      aw_done  <= aw_done_nxt;
      w_done   <= w_done_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    ar_done_nxt  = ar_done;
    aw_done_nxt  = aw_done;
    w_done_nxt   = w_done;
    last_gnt_nxt = last_gnt;
    aw_fin       = 1'b0;
    w_fin        = 1'b0;

    ifu_ar_ready = 1'b0;
    ifu_r_data   = '0;
    ifu_r_resp   = 2'b00;
    ifu_r_valid  = 1'b0;
    lsu_ar_ready = 1'b0;
    lsu_r_data   = '0;
    lsu_r_resp   = 2'b00;
    lsu_r_valid  = 1'b0;
    lsu_aw_ready = 1'b0;
    lsu_w_ready  = 1'b0;
    lsu_b_resp   = 2'b00;
    lsu_b_valid  = 1'b0;
    m_ar_addr    = '0;
    m_ar_valid   = 1'b0;
    m_r_ready    = 1'b0;
    m_aw_addr    = '0;
    m_aw_valid   = 1'b0;
    m_w_data     = '0;
    m_w_strb     = '0;
    m_w_valid    = 1'b0;
    m_b_ready    = 1'b0;

    case (state)
      IDLE: begin
        // Writes beat any read; simultaneous reads go to LSU unless
        // round-robin is enabled and LSU was the last one served.
        if (lsu_aw_valid && lsu_w_valid) begin
          state_nxt = LSU_WR;
        end else if (lsu_ar_valid && ifu_ar_valid) begin
          state_nxt = (RR_EN && (last_gnt == GNT_LSU)) ? IFU_RD : LSU_RD;
        end else if (lsu_ar_valid) begin
          state_nxt = LSU_RD;
        end else if (ifu_ar_valid) begin
          state_nxt = IFU_RD;
        end
      end

      IFU_RD: begin
        m_ar_addr    = ifu_ar_addr;
        m_ar_valid   = ifu_ar_valid & ~ar_done;
        ifu_ar_ready = m_ar_ready & ~ar_done;
        ifu_r_data   = m_r_data;
        ifu_r_resp   = m_r_resp;
        ifu_r_valid  = m_r_valid;
        m_r_ready    = ifu_r_ready;
        if (m_ar_valid && m_ar_ready) ar_done_nxt = 1'b1;
        if (m_r_valid && ifu_r_ready) begin
          state_nxt    = IDLE;
          ar_done_nxt  = 1'b0;
          last_gnt_nxt = GNT_IFU;
        end
      end

      LSU_RD: begin
        m_ar_addr    = lsu_ar_addr;
        m_ar_valid   = lsu_ar_valid & ~ar_done;
        lsu_ar_ready = m_ar_ready & ~ar_done;
        lsu_r_data   = m_r_data;
        lsu_r_resp   = m_r_resp;
        lsu_r_valid  = m_r_valid;
        m_r_ready    = lsu_r_ready;
        if (m_ar_valid && m_ar_ready) ar_done_nxt = 1'b1;
        if (m_r_valid && lsu_r_ready) begin
          state_nxt    = IDLE;
          ar_done_nxt  = 1'b0;
          last_gnt_nxt = GNT_LSU;
        end
      end

      LSU_WR: begin
        m_aw_addr    = lsu_aw_addr;
        m_aw_valid   = lsu_aw_valid & ~aw_done;
        lsu_aw_ready = m_aw_ready & ~aw_done;
        m_w_data     = lsu_w_data;
        m_w_strb     = lsu_w_strb;
        m_w_valid    = lsu_w_valid & ~w_done;
        lsu_w_ready  = m_w_ready & ~w_done;
        if (m_aw_valid && m_aw_ready) aw_done_nxt = 1'b1;
        if (m_w_valid && m_w_ready) w_done_nxt = 1'b1;
        // A phase counts as finished in the cycle its handshake happens, so
        // B can open in the same cycle the last of AW/W is accepted.
        aw_fin = aw_done | (m_aw_valid & m_aw_ready);
        w_fin  = w_done | (m_w_valid & m_w_ready);
        if (aw_fin && w_fin) begin
          lsu_b_resp  = m_b_resp;
          lsu_b_valid = m_b_valid;
          m_b_ready   = lsu_b_ready;
          if (m_b_valid && lsu_b_ready) begin
            state_nxt   = IDLE;
            aw_done_nxt = 1'b0;
            w_done_nxt  = 1'b0;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter. Two instances share all inputs: dut uses
// fixed priority, dut_rr uses round-robin. Inputs are driven 2 time units
// after the rising edge and outputs are checked 1 unit later.
module tb_axi_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] ifu_ar_addr, lsu_ar_addr, lsu_aw_addr;
  logic          ifu_ar_valid, ifu_r_ready, lsu_ar_valid, lsu_r_ready;
  logic          lsu_aw_valid, lsu_w_valid, lsu_b_ready;
  logic [DW-1:0] lsu_w_data, m_r_data;
  logic [SW-1:0] lsu_w_strb;
  logic          m_ar_ready, m_r_valid, m_aw_ready, m_w_ready, m_b_valid;
  logic [1:0]    m_r_resp, m_b_resp;

  // fixed-priority instance outputs
  logic          ifu_ar_ready, ifu_r_valid, lsu_ar_ready, lsu_r_valid;
  logic [DW-1:0] ifu_r_data, lsu_r_data, m_w_data;
  logic [1:0]    ifu_r_resp, lsu_r_resp, lsu_b_resp, dbg_state;
  logic          lsu_aw_ready, lsu_w_ready, lsu_b_valid;
  logic [AW-1:0] m_ar_addr, m_aw_addr;
  logic          m_ar_valid, m_r_ready, m_aw_valid, m_w_valid, m_b_ready;
  logic [SW-1:0] m_w_strb;

  // round-robin instance outputs
  logic          rr_ifu_ar_ready, rr_ifu_r_valid, rr_lsu_ar_ready, rr_lsu_r_valid;
  logic [DW-1:0] rr_ifu_r_data, rr_lsu_r_data, rr_m_w_data;
  logic [1:0]    rr_ifu_r_resp, rr_lsu_r_resp, rr_lsu_b_resp, rr_dbg_state;
  logic          rr_lsu_aw_ready, rr_lsu_w_ready, rr_lsu_b_valid;
  logic [AW-1:0] rr_m_ar_addr, rr_m_aw_addr;
  logic          rr_m_ar_valid, rr_m_r_ready, rr_m_aw_valid, rr_m_w_valid, rr_m_b_ready;
  logic [SW-1:0] rr_m_w_strb;

  axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .RR_EN(1'b0)) dut (
    .clk(clk), .rst(rst),
    .ifu_ar_addr(ifu_ar_addr), .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(ifu_ar_ready),
    .ifu_r_data(ifu_r_data), .ifu_r_resp(ifu_r_resp), .ifu_r_valid(ifu_r_valid), .ifu_r_ready(ifu_r_ready),
    .lsu_ar_addr(lsu_ar_addr), .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(lsu_ar_ready),
    .lsu_r_data(lsu_r_data), .lsu_r_resp(lsu_r_resp), .lsu_r_valid(lsu_r_valid), .lsu_r_ready(lsu_r_ready),
    .lsu_aw_addr(lsu_aw_addr), .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(lsu_aw_ready),
    .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb), .lsu_w_valid(lsu_w_valid), .lsu_w_ready(lsu_w_ready),
    .lsu_b_resp(lsu_b_resp), .lsu_b_valid(lsu_b_valid), .lsu_b_ready(lsu_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .m_aw_addr(m_aw_addr), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .dbg_state(dbg_state)
  );

  axi_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STRB_W(SW), .RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .ifu_ar_addr(ifu_ar_addr), .ifu_ar_valid(ifu_ar_valid), .ifu_ar_ready(rr_ifu_ar_ready),
    .ifu_r_data(rr_ifu_r_data), .ifu_r_resp(rr_ifu_r_resp), .ifu_r_valid(rr_ifu_r_valid), .ifu_r_ready(ifu_r_ready),
    .lsu_ar_addr(lsu_ar_addr), .lsu_ar_valid(lsu_ar_valid), .lsu_ar_ready(rr_lsu_ar_ready),
    .lsu_r_data(rr_lsu_r_data), .lsu_r_resp(rr_lsu_r_resp), .lsu_r_valid(rr_lsu_r_valid), .lsu_r_ready(lsu_r_ready),
    .lsu_aw_addr(lsu_aw_addr), .lsu_aw_valid(lsu_aw_valid), .lsu_aw_ready(rr_lsu_aw_ready),
    .lsu_w_data(lsu_w_data), .lsu_w_strb(lsu_w_strb), .lsu_w_valid(lsu_w_valid), .lsu_w_ready(rr_lsu_w_ready),
    .lsu_b_resp(rr_lsu_b_resp), .lsu_b_valid(rr_lsu_b_valid), .lsu_b_ready(lsu_b_ready),
    .m_ar_addr(rr_m_ar_addr), .m_ar_valid(rr_m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(rr_m_r_ready),
    .m_aw_addr(rr_m_aw_addr), .m_aw_valid(rr_m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(rr_m_w_data), .m_w_strb(rr_m_w_strb), .m_w_valid(rr_m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(rr_m_b_ready),
    .dbg_state(rr_dbg_state)
  );

  localparam logic [1:0] S_IDLE = 2'd0, S_IFU = 2'd1, S_LSU = 2'd2, S_WR = 2'd3;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // advance to 2 units after the next rising edge (input drive point)
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    ifu_ar_addr = '0; ifu_ar_valid = 0; ifu_r_ready = 0;
    lsu_ar_addr = '0; lsu_ar_valid = 0; lsu_r_ready = 0;
    lsu_aw_addr = '0; lsu_aw_valid = 0; lsu_w_data = '0; lsu_w_strb = '0;
    lsu_w_valid = 0; lsu_b_ready = 0;
    m_ar_ready = 0; m_r_data = '0; m_r_resp = 2'b00; m_r_valid = 0;
    m_aw_ready = 0; m_w_ready = 0; m_b_resp = 2'b00; m_b_valid = 0;

    // ---- reset ----
    cyc(); cyc();
    #1;
    check("rst_state", dbg_state, S_IDLE);
    check("rst_m_ar_valid", m_ar_valid, 0);
    check("rst_m_aw_valid", m_aw_valid, 0);
    check("rst_lsu_b_valid", lsu_b_valid, 0);
    rst = 0;

    // ---- IFU read alone ----
    cyc();
    ifu_ar_addr = 32'h8000_0000; ifu_ar_valid = 1; ifu_r_ready = 1; m_ar_ready = 1;
    #1;
    check("ifu_idle_m_ar_valid", m_ar_valid, 0);
    check("ifu_idle_ar_ready", ifu_ar_ready, 0);
    cyc(); #1;
    check("ifu_state", dbg_state, S_IFU);
    check("ifu_m_ar_valid", m_ar_valid, 1);
    check("ifu_m_ar_addr", m_ar_addr, 64'h8000_0000);
    check("ifu_ar_ready", ifu_ar_ready, 1);
    cyc(); #1;
    check("ifu_no_reissue", m_ar_valid, 0);
    check("ifu_lsu_r_valid_w1", lsu_r_valid, 0);
    cyc();
    m_r_valid = 1; m_r_data = 64'h0000_0013_0000_0093; m_r_resp = 2'b00;
    #1;
    check("ifu_r_valid", ifu_r_valid, 1);
    check("ifu_r_data", ifu_r_data, 64'h0000_0013_0000_0093);
    check("ifu_lsu_r_valid", lsu_r_valid, 0);
    check("ifu_m_r_ready", m_r_ready, 1);
    cyc();
    ifu_ar_valid = 0; m_r_valid = 0; m_r_data = '0;
    #1;
    check("ifu_back_idle", dbg_state, S_IDLE);
    check("ifu_idle_r_valid", ifu_r_valid, 0);

    // ---- LSU read, held valid, r after 5 cycles, SLVERR ----
    cyc();
    lsu_ar_addr = 32'h8000_2000; lsu_ar_valid = 1; lsu_r_ready = 1; m_ar_ready = 1;
    cyc(); #1;
    check("lsu_state", dbg_state, S_LSU);
    check("lsu_m_ar_valid", m_ar_valid, 1);
    check("lsu_m_ar_addr", m_ar_addr, 64'h8000_2000);
    check("lsu_ar_ready", lsu_ar_ready, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check("lsu_held_m_ar_valid", m_ar_valid, 0);
      check("lsu_held_ar_ready", lsu_ar_ready, 0);
    end
    cyc();
    m_r_valid = 1; m_r_data = 64'h1234_5678_9ABC_DEF0; m_r_resp = 2'b10;
    #1;
    check("lsu_r_valid", lsu_r_valid, 1);
    check("lsu_r_data", lsu_r_data, 64'h1234_5678_9ABC_DEF0);
    check("lsu_r_resp_slverr", lsu_r_resp, 2'b10);
    check("lsu_ifu_r_valid", ifu_r_valid, 0);
    cyc();
    lsu_ar_valid = 0; m_r_valid = 0; m_r_resp = 2'b00; m_r_data = '0;
    #1;
    check("lsu_err_back_idle", dbg_state, S_IDLE);

    // ---- simultaneous reads: fixed gives LSU, round-robin (last=LSU) gives IFU ----
    cyc();
    ifu_ar_addr = 32'h8000_0040; ifu_ar_valid = 1;
    lsu_ar_addr = 32'h8000_1000; lsu_ar_valid = 1;
    cyc(); #1;
    check("sim_fixed_state", dbg_state, S_LSU);
    check("sim_fixed_addr", m_ar_addr, 64'h8000_1000);
    check("sim_fixed_ifu_ready", ifu_ar_ready, 0);
    check("sim_rr_state", rr_dbg_state, S_IFU);
    check("sim_rr_addr", rr_m_ar_addr, 64'h8000_0040);
    cyc();
    m_r_valid = 1; m_r_data = 64'h0000_0000_AAAA_5555;
    #1;
    check("sim_fixed_lsu_r", lsu_r_valid, 1);
    check("sim_rr_ifu_r", rr_ifu_r_valid, 1);
    check("sim_rr_lsu_r", rr_lsu_r_valid, 0);
    cyc();
    m_r_valid = 0; lsu_ar_valid = 0;
    #1;
    check("sim_idle_gap", dbg_state, S_IDLE);
    check("sim_idle_m_ar_valid", m_ar_valid, 0);
    cyc(); #1;
    check("sim_ifu_next", dbg_state, S_IFU);
    check("sim_ifu_next_addr", m_ar_addr, 64'h8000_0040);
    cyc();
    m_r_valid = 1; m_r_data = 64'h0000_0000_0000_0013;
    #1;
    check("sim_ifu_next_r", ifu_r_valid, 1);
    cyc();
    m_r_valid = 0; ifu_ar_valid = 0; m_ar_ready = 0;

    // ---- write: W accepted in cycle 1, AW in cycle 3, early B held ----
    lsu_aw_addr = 32'h8000_3000; lsu_aw_valid = 1;
    lsu_w_data = 64'h0000_0000_DEAD_BEEF; lsu_w_strb = 8'h0F; lsu_w_valid = 1;
    lsu_b_ready = 1;
    cyc();
    m_w_ready = 1;
    #1;
    check("wr_state", dbg_state, S_WR);
    check("wr_c1_m_w_valid", m_w_valid, 1);
    check("wr_c1_m_w_data", m_w_data, 64'h0000_0000_DEAD_BEEF);
    check("wr_c1_m_w_strb", m_w_strb, 8'h0F);
    check("wr_c1_lsu_w_ready", lsu_w_ready, 1);
    check("wr_c1_m_aw_valid", m_aw_valid, 1);
    check("wr_c1_lsu_aw_ready", lsu_aw_ready, 0);
    cyc();
    m_b_valid = 1; m_b_resp = 2'b00;
    #1;
    check("wr_c2_w_no_reissue", m_w_valid, 0);
    check("wr_c2_m_b_ready_held", m_b_ready, 0);
    check("wr_c2_lsu_b_valid", lsu_b_valid, 0);
    cyc();
    m_aw_ready = 1;
    #1;
    check("wr_c3_m_aw_addr", m_aw_addr, 64'h8000_3000);
    check("wr_c3_lsu_aw_ready", lsu_aw_ready, 1);
    check("wr_c3_m_b_ready", m_b_ready, 1);
    check("wr_c3_lsu_b_valid", lsu_b_valid, 1);
    cyc();
    lsu_aw_valid = 0; lsu_w_valid = 0; m_b_valid = 0; m_aw_ready = 0; m_w_ready = 0;
    #1;
    check("wr_back_idle", dbg_state, S_IDLE);
    check("wr_idle_lsu_b_valid", lsu_b_valid, 0);

    // ---- reset mid-write after AW accepted, then fresh write re-issues AW ----
    cyc();
    lsu_aw_addr = 32'h8000_4000; lsu_aw_valid = 1; lsu_w_valid = 1;
    lsu_w_data = 64'h1111_2222_3333_4444; lsu_w_strb = 8'hFF;
    m_aw_ready = 1;
    cyc(); #1;
    check("rw_aw_issue", m_aw_valid, 1);
    cyc(); #1;
    check("rw_aw_done", m_aw_valid, 0);
    check("rw_w_pending", m_w_valid, 1);
    rst = 1;
    cyc();
    rst = 0;
    #1;
    check("rw_rst_state", dbg_state, S_IDLE);
    check("rw_rst_m_aw_valid", m_aw_valid, 0);
    check("rw_rst_m_w_valid", m_w_valid, 0);
    check("rw_rst_rr_state", rr_dbg_state, S_IDLE);
    cyc();
    m_w_ready = 1; m_b_valid = 1; m_b_resp = 2'b11;
    #1;
    check("rw_aw_reissue", m_aw_valid, 1);
    check("rw_same_cycle_b_ready", m_b_ready, 1);
    check("rw_b_valid", lsu_b_valid, 1);
    check("rw_b_resp_decerr", lsu_b_resp, 2'b11);
    cyc();
    lsu_aw_valid = 0; lsu_w_valid = 0; m_b_valid = 0; m_aw_ready = 0; m_w_ready = 0;
    #1;
    check("rw_back_idle", dbg_state, S_IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
